// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int m;
    int w;
    m = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int num_outs);
    int w;
    w = $clog2(num_outs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Software request / stage-ready inputs and sequenced reset outputs of rst_seq.
interface rst_seq_if #(
  parameter int NUM_OUTS = 3
);
  logic                sw_rst_req;
  logic [NUM_OUTS-1:0] stage_rdy;
  logic [NUM_OUTS-1:0] rst_out;
  logic                seq_done;

  modport master (
    output sw_rst_req,
    output stage_rdy,
    input  rst_out,
    input  seq_done
  );

  modport slave (
    input  sw_rst_req,
    input  stage_rdy,
    output rst_out,
    output seq_done
  );
endinterface

// File: rtl/rst_seq_cnt.sv
// Clearable up-counter that saturates at a run-time terminal value; at_term_o
// flags the terminal value combinationally from the registered count.
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         at_term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != term_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq.sv
// Releases NUM_OUTS active-low resets in order: HOLD_CYCLES after reset, then one
// per STEP_CYCLES gap once the previous stage reports ready; sw_rst_req replays it.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  rst_seq_if.slave bus
);

  localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW = idx_width(NUM_OUTS);

  localparam logic [CW-1:0]       HOLD_TERM = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]       STEP_TERM = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0]       LAST_IDX  = IW'(NUM_OUTS - 1);
  localparam logic [NUM_OUTS-1:0] OUT_LSB   = NUM_OUTS'(1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                done_q, done_d;

  logic          cnt_clr;
  logic [CW-1:0] cnt_term;
  logic          at_term;
  logic          rdy_sel;

  rst_seq_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (cnt_clr),
    .term_i    (cnt_term),
    .at_term_o (at_term)
  );

  // Only the stage currently being waited on is looked at.
  always_comb begin
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_OUTS; i++) begin
      if (idx_q == IW'(i)) begin
        rdy_sel = bus.stage_rdy[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    cnt_clr   = 1'b0;
    cnt_term  = HOLD_TERM;

    if (bus.sw_rst_req) begin
      state_d   = ST_HOLD;
      idx_d     = '0;
      rst_out_d = '0;
      done_d    = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          cnt_term = HOLD_TERM;
          if (at_term) begin
            rst_out_d = OUT_LSB;
            idx_d     = '0;
            cnt_clr   = 1'b1;
            state_d   = ST_STEP;
          end
        end
        ST_STEP: begin
          cnt_term = STEP_TERM;
          if (at_term && rdy_sel) begin
            cnt_clr = 1'b1;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              // Shifting in a one keeps the outputs a thermometer code.
              idx_d     = idx_q + IW'(1);
              rst_out_d = (rst_out_q << 1) | OUT_LSB;
            end
          end
        end
        ST_DONE: begin
          cnt_clr = 1'b1;
        end
        default: begin
          state_d   = ST_HOLD;
          idx_d     = '0;
          rst_out_d = '0;
          done_d    = 1'b0;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_HOLD;
      idx_q     <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.seq_done = done_q;

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset-release sequencer sitting directly downstream of the two-flop reset synchronizer. It takes the synchronized active-low reset and releases up to `NUM_OUTS` block-level resets one at a time, in fixed order. It holds every stage in reset for a programmable interval, then waits a minimum gap plus a per-stage ready handshake before releasing the next stage. It also accepts a synchronous software reset request that re-runs the whole sequence.

## Interface
- `NUM_OUTS`, 3: number of sequenced reset outputs; must be ≥ 1.
- `HOLD_CYCLES`, 16: CLK edges all outputs stay asserted after `RST` deasserts; must be ≥ 1.
- `STEP_CYCLES`, 4: minimum CLK edges between consecutive releases; must be ≥ 1.

Ports:
- `CLK` in 1: the only clock.
- `RST` in 1: reset, **asynchronous, active-low**. Driven by the synchronizer output, so deassertion is already CLK-aligned.
- `SW_RST_REQ` in 1: synchronous software reset request, active-high level.
- `STAGE_RDY` in `NUM_OUTS`: bit i is stage i's "out of reset and ready" indication.
- `RST_OUT` out `NUM_OUTS`: bit i is the active-low reset for stage i.
- `SEQ_DONE` out 1: high once the whole sequence has completed.

## Operation
- **States:**
  - HOLD: all outputs low; the counter runs.
  - STEP(i): outputs 0..i high; waits for the gap and the ready handshake.
  - DONE: sequence complete.
- **Async reset** (`RST`=0): state=HOLD, counter=0, stage index=0, `RST_OUT`=all 0, `SEQ_DONE`=0. The same values apply immediately if `RST` is asserted mid-sequence.
- **HOLD:**
  - The counter increments each edge.
  - On the edge where counter = `HOLD_CYCLES`-1: set `RST_OUT[0]`=1, clear the counter, go to STEP(0).
- **STEP(i):**
  - The counter increments, saturating at `STEP_CYCLES`-1.
  - On an edge with counter = `STEP_CYCLES`-1 and `STAGE_RDY[i]`=1:
    - If i < `NUM_OUTS`-1: set `RST_OUT[i+1]`=1, clear the counter, go to STEP(i+1).
    - Else: set `SEQ_DONE`=1 and go to DONE.
  - If `STAGE_RDY[i]`=0, stay in STEP(i) with no timeout. Release order is never skipped.
- **DONE:**
  - Outputs are static.
  - `STAGE_RDY` is ignored.
- **`STAGE_RDY` bits:** bits of stages not yet released are ignored.
- **`SW_RST_REQ`:** sampled every edge and has the highest priority below `RST`. When it is 1, the next edge sets `RST_OUT`=all 0, `SEQ_DONE`=0, counter=0, state=HOLD.
  - While it remains high, the counter stays 0.
  - HOLD counting starts on the first edge it is sampled low.
- **Arithmetic and widths:**
  - Counter width is `$clog2(max(HOLD_CYCLES,STEP_CYCLES))`, minimum 1.
  - Stage index width is `$clog2(NUM_OUTS)`, minimum 1.
  - There is no wrap-around; compares are equality against constant-1.
- **Output invariants:**
  - `RST_OUT` is always a thermometer code: bit i high implies every bit below i is high.
  - `RST_OUT` and `SEQ_DONE` are registered outputs with no combinational path from inputs.

## Timing
- Edge 1 is the first CLK posedge sampled with `RST`=1 and `SW_RST_REQ`=0.
- With all ready bits high:
  - `RST_OUT[i]` rises at edge `HOLD_CYCLES` + i·`STEP_CYCLES`.
  - `SEQ_DONE` rises at edge `HOLD_CYCLES` + `NUM_OUTS`·`STEP_CYCLES`.
- If `STAGE_RDY[i]` rises at edge k, after the gap has already expired:
  - The next release happens at edge k (it is sampled on that edge).
  - The counter does not restart.
- `SW_RST_REQ` to all-outputs-low latency: 1 edge.
- `RST` to all-outputs-low latency: 0 edges (asynchronous).

## Structure
- Shared package `rst_seq_pkg` holds:
  - the state encodings HOLD, STEP, DONE;
  - the counter-width and index-width helper functions.
- One natural sub-module: `rst_seq_cnt`, a clearable, saturating up-counter with a terminal-value compare output.
  - It takes a dynamic terminal value: `HOLD_CYCLES`-1 in HOLD, `STEP_CYCLES`-1 in STEP.
  - It is reset by `RST`.
- FSM, stage index and output registers live in `rst_seq`.

## Test plan
All scenarios use `NUM_OUTS`=3, `HOLD_CYCLES`=4, `STEP_CYCLES`=2 unless stated.
- **Power-up, `STAGE_RDY`=3'b111:** `RST_OUT` steps 000→001@4→011@6→111@8; `SEQ_DONE`=1@10.
- **Ready stall:** `STAGE_RDY[1]` held 0 until edge 20. `RST_OUT`=011 from 6 through 19, 111@20, `SEQ_DONE`@22.
- **Software reset in DONE:** `SW_RST_REQ` pulsed 1 cycle at edge 30. Outputs are 000 and `SEQ_DONE`=0 after edge 30; the sequence replays 001@34, 011@36, 111@38.
- **Async reset mid-sequence:** `RST` driven low between edges 7 and 8. Outputs go to 000 immediately without a clock edge; after release the full sequence repeats from edge 1.
- **Corner parameters, all ready:** `NUM_OUTS`=1, `HOLD_CYCLES`=1, `STEP_CYCLES`=1. `RST_OUT`=1@1, `SEQ_DONE`@2.
- **Thermometer assertion:** a random `STAGE_RDY` and `SW_RST_REQ` run of 10k cycles never violates the thermometer invariant.
